// File: rtl/imem_port_arbiter.sv
// Arbitrates one synchronous-read imem port between instruction fetch (IF) and load (LS).
// LS normally wins, but a bounded LS streak guarantees that a pending fetch still progresses.
module imem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [SW-1:0] STREAK_ONE = SW'(1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    owner_e            owner_q, owner_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
    logic              if_gnt_s, ls_gnt_s;

    // Grant selection, streak and owner next-state.
    always_comb begin
        if_gnt_s = 1'b0;
        ls_gnt_s = 1'b0;
        owner_d  = OWN_NONE;
        streak_d = streak_q;
        if (rst) begin
            if_gnt_s = 1'b0;
            ls_gnt_s = 1'b0;
        end else if (ls_req_i && (!if_req_i || (streak_q != STREAK_MAX))) begin
            ls_gnt_s = 1'b1;
        end else if (if_req_i) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            ls_gnt_s = 1'b0;
        end

        if (if_gnt_s) begin
            owner_d = OWN_IF;
        end else if (ls_gnt_s) begin
            owner_d = OWN_LS;
        end else begin
            owner_d = OWN_NONE;
        end

        // The streak only measures how long a waiting fetch has been passed over.
        if (!if_req_i || if_gnt_s) begin
            streak_d = {SW{1'b0}};
        end else if (ls_gnt_s && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_ONE;
        end else begin
            streak_d = streak_q;
        end
    end

    // Memory request and response routing.
    always_comb begin
        if_gnt_o    = if_gnt_s;
        ls_gnt_o    = ls_gnt_s;
        mem_en_o    = if_gnt_s | ls_gnt_s;
        if (if_gnt_s) begin
            mem_addr_o = if_addr_i;
        end else if (ls_gnt_s) begin
            mem_addr_o = ls_addr_i;
        end else begin
            mem_addr_o = {ADDR_W{1'b0}};
        end
        if_rvalid_o = (owner_q == OWN_IF);
        ls_rvalid_o = (owner_q == OWN_LS);
        // The owner sees live memory data in its response cycle; the register holds it afterwards.
        if (owner_q == OWN_IF) begin
            if_rdata_o = mem_rdata_i;
        end else begin
            if_rdata_o = if_rdata_q;
        end
        if (owner_q == OWN_LS) begin
            ls_rdata_o = mem_rdata_i;
        end else begin
            ls_rdata_o = ls_rdata_q;
        end
    end

    // State registers and response data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            streak_q   <= {SW{1'b0}};
            if_rdata_q <= {DATA_W{1'b0}};
            ls_rdata_q <= {DATA_W{1'b0}};
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
            if (owner_q == OWN_IF) begin
                if_rdata_q <= mem_rdata_i;
            end else begin
                if_rdata_q <= if_rdata_q;
            end
            if (owner_q == OWN_LS) begin
                ls_rdata_q <= mem_rdata_i;
            end else begin
                ls_rdata_q <= ls_rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized and directed bench for imem_port_arbiter against a request-level reference model.
module tb_imem_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          ls_req_i = 1'b0;
    logic [AW-1:0] ls_addr_i = '0;
    logic          ls_gnt_o, ls_rvalid_o;
    logic [DW-1:0] ls_rdata_o;
    logic          mem_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rdata_i = '0;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: waiting-fetch bypass count, last grant, held data per port.
    int            m_streak = 0;
    int            m_owner  = 0;   // 0 none, 1 IF, 2 LS
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_if_hold = '0;
    logic [DW-1:0] m_ls_hold = '0;

    imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_addr_i(ls_addr_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {a ^ 14'h2a5b, 2'b10, a, 2'b01};
    endfunction

    // Synchronous-read memory behind the port.
    always @(posedge clk) begin
        if (mem_en_o) mem_rdata_i <= memf(mem_addr_o);
    end

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_streak  = 0;
        m_owner   = 0;
        m_addr    = '0;
        m_if_hold = '0;
        m_ls_hold = '0;
    endfunction

    // One cycle: drive after the edge, compare mid-cycle, then advance the model.
    task automatic step(input logic ir, input logic [AW-1:0] ia, input logic lr, input logic [AW-1:0] la);
        int            g;
        logic [AW-1:0] ga;
        @(posedge clk);
        #1;
        if_req_i = ir; if_addr_i = ia; ls_req_i = lr; ls_addr_i = la;
        @(negedge clk);
        if (lr && (!ir || m_streak < MS)) begin g = 2; ga = la; end
        else if (ir) begin g = 1; ga = ia; end
        else begin g = 0; ga = '0; end
        check("if_gnt", if_gnt_o, (g == 1));
        check("ls_gnt", ls_gnt_o, (g == 2));
        check("mem_en", mem_en_o, (g != 0));
        check("mem_addr", mem_addr_o, ga);
        check("if_rvalid", if_rvalid_o, (m_owner == 1));
        check("ls_rvalid", ls_rvalid_o, (m_owner == 2));
        if (m_owner == 1) m_if_hold = memf(m_addr);
        if (m_owner == 2) m_ls_hold = memf(m_addr);
        check("if_rdata", if_rdata_o, m_if_hold);
        check("ls_rdata", ls_rdata_o, m_ls_hold);
        if (!ir || g == 1) m_streak = 0;
        else if (g == 2 && m_streak < MS) m_streak++;
        m_owner = g;
        m_addr  = ga;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_gnt"}, if_gnt_o, 32'd0);
        check({tag, "_ls_gnt"}, ls_gnt_o, 32'd0);
        check({tag, "_mem_en"}, mem_en_o, 32'd0);
        check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        check({tag, "_if_rvalid"}, if_rvalid_o, 32'd0);
        check({tag, "_ls_rvalid"}, ls_rvalid_o, 32'd0);
        check({tag, "_if_rdata"}, if_rdata_o, 32'd0);
        check({tag, "_ls_rdata"}, ls_rdata_o, 32'd0);
    endtask

    initial begin
        logic          ip, lp;
        logic [AW-1:0] ia, la;

        // Reset state, with requests asserted so gating is exercised.
        if_req_i = 1'b1; ls_req_i = 1'b1; ls_addr_i = 14'h0055;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0; if_req_i = 1'b0; ls_req_i = 1'b0;
        model_reset();

        // Reset mid-response: response to an LS grant is dropped.
        step(1'b0, 14'h0, 1'b1, 14'h0123);
        check("t1_ls_gnt", ls_gnt_o, 32'd1);
        step(1'b0, 14'h0, 1'b1, 14'h0124);
        @(posedge clk); #1;
        rst = 1'b1; ls_req_i = 1'b1;
        #2;
        check_all_zero("t1_midrst");
        @(posedge clk); #1;
        rst = 1'b0; ls_req_i = 1'b0;
        model_reset();
        @(negedge clk);
        check("t1_ls_rvalid", ls_rvalid_o, 32'd0);

        // IF-only stream of addresses 0..3.
        step(1'b0, 14'h0, 1'b0, 14'h0);
        for (int i = 0; i < 5; i++) begin
            step((i < 4), AW'(i), 1'b0, 14'h0);
            check("t2_if_gnt", if_gnt_o, (i < 4));
            check("t2_if_rvalid", if_rvalid_o, (i > 0));
            if (i > 0) check("t2_if_rdata", if_rdata_o, memf(AW'(i - 1)));
        end

        // Both held requesting: LS x4 then IF, repeating.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 14'h0100, 1'b1, 14'h0200);
            check("t3_ls_gnt", ls_gnt_o, ((i % 5) != 4));
        end

        // LS alone for two grants, then IF joins: four more LS grants before IF.
        step(1'b0, 14'h0, 1'b0, 14'h0);
        for (int i = 0; i < 7; i++) begin
            step((i >= 2), 14'h0300, 1'b1, AW'(14'h0400 + i));
            check("t4_if_gnt", if_gnt_o, (i == 6));
        end

        // Alternating owners: each response lands only on its own port.
        step(1'b1, 14'h0010, 1'b0, 14'h0);
        step(1'b0, 14'h0, 1'b1, 14'h0020);
        check("t5_if_rdata", if_rdata_o, memf(14'h0010));
        check("t5_ls_rvalid", ls_rvalid_o, 32'd0);
        step(1'b0, 14'h0, 1'b0, 14'h0);
        check("t5_ls_rdata", ls_rdata_o, memf(14'h0020));
        check("t5_if_rdata_held", if_rdata_o, memf(14'h0010));

        // Withdrawn LS request while losing to a starved IF.
        for (int i = 0; i < 4; i++) step(1'b1, 14'h0500, 1'b1, 14'h0600);
        step(1'b1, 14'h0500, 1'b1, 14'h0601);
        check("t6_ls_gnt", ls_gnt_o, 32'd0);
        check("t6_if_gnt", if_gnt_o, 32'd1);
        step(1'b0, 14'h0, 1'b0, 14'h0);
        check("t6_ls_rvalid", ls_rvalid_o, 32'd0);
        check("t6_if_rvalid", if_rvalid_o, 32'd1);

        // Randomized requesters obeying hold-until-grant, with occasional withdrawal.
        ip = 1'b0; lp = 1'b0; ia = '0; la = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!ip && ($urandom % 4 != 0)) begin ip = 1'b1; ia = AW'($urandom); end
            else if (ip && ($urandom % 16 == 0)) ip = 1'b0;
            if (!lp && ($urandom % 3 != 0)) begin lp = 1'b1; la = AW'($urandom); end
            else if (lp && ($urandom % 16 == 0)) lp = 1'b0;
            step(ip, ia, lp, la);
            if (if_gnt_o) ip = 1'b0;
            if (ls_gnt_o) lp = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
